ppu_pixel_fifo: RTL and testbench
=================================

Name: ppu_pixel_fifo

Overview:
- Parametrised successor to the PPU's 2-bitplane background shift register.
- Buffers fetched BG tile rows in a DEPTH-entry pixel FIFO and overlays an 8-entry sprite FIFO that stays aligned with the BG head.
- Applies fine-scroll discard (SCX[2:0]), BG/OBJ priority mixing and palette mapping (BGP/OBP0/OBP1).
- Emits one 2-bit shade per accepted pop through a valid/ready output register. Sits between the PPU fetcher and the LCD pixel sink.

Parameters:
DEPTH, 16, BG FIFO entries; power of two, minimum 16.
OBJ_EN, 1, 1 = sprite FIFO and mixing present; 0 = obj_ready tied 0, obj path removed.
PAL_EN, 1, 1 = output palette-mapped shade; 0 = output raw 2-bit colour index.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
line_start  in  1  clear both FIFOs, latch discard; start of each DRAW period
discard  in  3  fine-scroll pixels to drop after line_start (SCX[2:0])
bg_load  in  1  push 8 BG pixels
bg_lo  in  8  BG bitplane 0, bit 7 = leftmost
bg_hi  in  8  BG bitplane 1, bit 7 = leftmost
bg_ready  out  1  room for 8 pixels: bg_count <= DEPTH-8
obj_load  in  1  merge 8 sprite pixels at FIFO head
obj_lo  in  8  sprite bitplane 0, bit 7 = leftmost
obj_hi  in  8  sprite bitplane 1
obj_pal  in  1  0 = OBP0, 1 = OBP1
obj_prio  in  1  1 = behind BG colours 1-3
obj_ready  out  1  bg_count >= 8 (and OBJ_EN)
bg_en  in  1  LCDC[0]; 0 forces BG colour index 0
bgp  in  8  BG palette
obp0  in  8  object palette 0 (bits 1:0 ignored)
obp1  in  8  object palette 1 (bits 1:0 ignored)
px_out  out  2  shade or colour index
px_valid  out  1  px_out valid
px_ready  in  1  sink accepts px_out
bg_count  out  $clog2(DEPTH+1)  BG entries held

Behaviour:
- Reset:
  - bg_count=0, sprite FIFO all transparent, discard counter=0.
  - px_valid=0, px_out=0.
  - bg_ready=1, obj_ready=0.
- line_start: highest priority.
  - Same cycle: empties both FIFOs, drops px_valid to 0, loads discard counter from discard.
  - Ignores any concurrent bg_load, obj_load or pop.
- BG push: bg_load && bg_ready appends 8 entries {bg_hi[i],bg_lo[i]} for i=7..0. bg_load without bg_ready is dropped; no error flag.
- Pop condition: bg_count>0 && (discard counter>0 || !px_valid || px_ready).
  - Each pop removes one BG entry and shifts the sprite FIFO by one; transparent fills the tail.
- Simultaneous push and pop:
  - bg_ready and obj_ready are evaluated on the pre-pop count.
  - bg_count += 8 - pop.
  - A push at bg_count = DEPTH-8 with pop is legal.
- Discard:
  - While the discard counter > 0, popped pixels are dropped: px_valid is not set and the counter decrements.
  - discard=0 means no drop. Discard does not wait on px_ready.
- Sprite merge: obj_load && obj_ready writes slot i (i=0 is head) with colour {obj_hi[7-i],obj_lo[7-i]}, obj_pal and obj_prio, only where the existing slot colour = 0.
  - Earlier-loaded sprites win overlaps.
  - If obj_load coincides with a pop, the merge targets the post-pop head, so slot i aligns with BG entry i after the pop.
  - obj_load without obj_ready is dropped.
- Mix, per non-discarded pop, using head values:
  - bgc = bg_en ? bg head colour : 0.
  - If objc != 0 && (!prio || bgc == 0): index objc through OBPn.
  - Otherwise: index bgc through BGP.
  - Palette lookup: shade = pal[2c+1:2c].
  - PAL_EN=0: px_out = selected raw index.
- Output register:
  - Latency is 1 cycle; pop in cycle N gives px_valid=1 in cycle N+1.
  - px_out is held stable while px_valid && !px_ready.
  - px_valid falls when accepted with no new pop.
- Full throughput: one pixel/cycle with px_ready held 1 and bg_load arriving at least once every 8 cycles.
- Reset or line_start mid-line: all in-flight pixels are lost, with no partial output.

Test Plan:
- Reset, then line_start with discard=0, bg_lo=8'hF0, bg_hi=8'hCC, bgp=8'hE4, px_ready=1.
  - Expect px_out sequence 3,3,1,1,2,2,0,0 on 8 consecutive valid cycles, first valid 2 cycles after bg_load.
- discard=5, same load.
  - Expect only 3 valid pixels: 2,0,0.
  - Expect bg_count to reach 0 after 8 pops.
- Push 8'hFF/8'hFF then obj_load obj_lo=8'h80, obj_hi=8'h00, obj_prio=0, obp0=8'hD0.
  - First pixel: objc=1, shade 0, from OBP0.
  - With obj_prio=1: first pixel shade 3 from BGP=E4.
- Fill to DEPTH with px_ready=0.
  - bg_ready=0 at bg_count=16; a further bg_load is dropped and bg_count stays 16.
  - px_out stays constant over 10 stalled cycles.
- Overlap: two obj_loads with slot 0 non-zero on both (first obj_pal=0, second obj_pal=1).
  - First sprite's colour and palette win.
- line_start asserted during active output with bg_count=9.
  - Next cycle: bg_count=0, px_valid=0, concurrent bg_load ignored.

Source files
------------

// File: rtl/ppu_pixel_fifo.sv
// PPU background/sprite pixel FIFO with fine-scroll discard,
// BG/OBJ priority mixing and palette mapping behind a valid/ready output.
module ppu_pixel_fifo #(
    parameter int DEPTH  = 16,
    parameter int OBJ_EN = 1,
    parameter int PAL_EN = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       line_start,
    input  logic [2:0]                 discard,
    input  logic                       bg_load,
    input  logic [7:0]                 bg_lo,
    input  logic [7:0]                 bg_hi,
    output logic                       bg_ready,
    input  logic                       obj_load,
    input  logic [7:0]                 obj_lo,
    input  logic [7:0]                 obj_hi,
    input  logic                       obj_pal,
    input  logic                       obj_prio,
    output logic                       obj_ready,
    input  logic                       bg_en,
    input  logic [7:0]                 bgp,
    input  logic [7:0]                 obp0,
    input  logic [7:0]                 obp1,
    output logic [1:0]                 px_out,
    output logic                       px_valid,
    input  logic                       px_ready,
    output logic [$clog2(DEPTH+1)-1:0] bg_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = 2 * DEPTH;
    localparam int PADW = FW - 16;
    localparam logic [CW-1:0] ROOM_MAX = CW'(DEPTH - 8);
    localparam logic [CW-1:0] ROW_PX = CW'(8);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    // BG FIFO is a packed shift vector, head pixel in bits [1:0]
    logic [FW-1:0] bg_q, bg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   scol_q, scol_d;
    logic [7:0]    spal_q, spal_d;
    logic [7:0]    sprio_q, sprio_d;
    logic [2:0]    disc_q, disc_d;
    logic          vld_q, vld_d;
    logic [1:0]    pix_q, pix_d;

    logic          pop;
    logic          push;
    logic          merge;
    logic [15:0]   bg_row;
    logic [15:0]   obj_row;
    logic [FW-1:0] bg_shift;
    logic [FW-1:0] bg_ins;
    logic [CW-1:0] base;
    logic [15:0]   scol_sh;
    logic [7:0]    spal_sh;
    logic [7:0]    sprio_sh;
    logic [7:0]    slot_free;
    logic [7:0]    take;
    logic [15:0]   cmask;

    logic [1:0]    bgc;
    logic [1:0]    objc;
    logic          opal;
    logic          oprio;
    logic          use_obj;
    logic [1:0]    idx;
    logic [7:0]    pal;
    logic [1:0]    shade;
    logic [1:0]    mix;

    assign bg_ready  = (cnt_q <= ROOM_MAX);
    assign obj_ready = (OBJ_EN != 0) && (cnt_q >= ROW_PX);
    assign px_out    = pix_q;
    assign px_valid  = vld_q;
    assign bg_count  = cnt_q;

    assign pop   = (cnt_q != CNT_ZERO)
                 && ((disc_q != 3'd0) || !vld_q || px_ready);
    assign push  = bg_load && bg_ready;
    assign merge = obj_load && obj_ready;

    // Leftmost pixel (bit 7) lands at the lowest slot of the row
    assign bg_row = {bg_hi[0], bg_lo[0], bg_hi[1], bg_lo[1],
                     bg_hi[2], bg_lo[2], bg_hi[3], bg_lo[3],
                     bg_hi[4], bg_lo[4], bg_hi[5], bg_lo[5],
                     bg_hi[6], bg_lo[6], bg_hi[7], bg_lo[7]};

    assign obj_row = {obj_hi[0], obj_lo[0], obj_hi[1], obj_lo[1],
                      obj_hi[2], obj_lo[2], obj_hi[3], obj_lo[3],
                      obj_hi[4], obj_lo[4], obj_hi[5], obj_lo[5],
                      obj_hi[6], obj_lo[6], obj_hi[7], obj_lo[7]};

    // Slots above bg_count are kept zero so a push can OR in its row
    assign bg_shift = pop ? {2'b00, bg_q[FW-1:2]} : bg_q;
    assign base     = cnt_q - {{(CW-1){1'b0}}, pop};
    assign bg_ins   = {{PADW{1'b0}}, bg_row} << {base, 1'b0};

    assign scol_sh  = pop ? {2'b00, scol_q[15:2]} : scol_q;
    assign spal_sh  = pop ? {1'b0, spal_q[7:1]} : spal_q;
    assign sprio_sh = pop ? {1'b0, sprio_q[7:1]} : sprio_q;

    for (genvar g = 0; g < 8; g++) begin : g_slot
        assign slot_free[g] = (scol_sh[2*g+1:2*g] == 2'b00);
        assign take[g]      = merge && slot_free[g];
        assign cmask[2*g+1:2*g] = {2{take[g]}};
    end

    assign bgc   = bg_en ? bg_q[1:0] : 2'b00;
    assign objc  = (OBJ_EN != 0) ? scol_q[1:0] : 2'b00;
    assign opal  = spal_q[0];
    assign oprio = sprio_q[0];

    always_comb begin
        use_obj = (objc != 2'b00) && (!oprio || (bgc == 2'b00));
        idx     = use_obj ? objc : bgc;
        pal     = bgp;
        if (use_obj) begin
            pal = opal ? obp1 : obp0;
        end
        unique case (idx)
            2'd0:    shade = pal[1:0];
            2'd1:    shade = pal[3:2];
            2'd2:    shade = pal[5:4];
            default: shade = pal[7:6];
        endcase
        mix = (PAL_EN != 0) ? shade : idx;
    end

    always_comb begin
        bg_d  = push ? (bg_shift | bg_ins) : bg_shift;
        cnt_d = cnt_q + (push ? ROW_PX : CNT_ZERO)
              - {{(CW-1){1'b0}}, pop};
        if (line_start) begin
            bg_d  = '0;
            cnt_d = '0;
        end
    end

    // Earlier sprites win: only transparent slots accept new pixels
    always_comb begin
        scol_d  = (scol_sh & ~cmask) | (obj_row & cmask);
        spal_d  = (spal_sh & ~take) | ({8{obj_pal}} & take);
        sprio_d = (sprio_sh & ~take) | ({8{obj_prio}} & take);
        if (line_start || (OBJ_EN == 0)) begin
            scol_d  = '0;
            spal_d  = '0;
            sprio_d = '0;
        end
    end

    always_comb begin
        disc_d = disc_q;
        if (line_start) begin
            disc_d = discard;
        end else if (pop && (disc_q != 3'd0)) begin
            disc_d = disc_q - 3'd1;
        end
    end

    always_comb begin
        vld_d = vld_q;
        pix_d = pix_q;
        if (line_start) begin
            vld_d = 1'b0;
        end else if (pop && (disc_q == 3'd0)) begin
            vld_d = 1'b1;
            pix_d = mix;
        end else if (px_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bg_q    <= '0;
            cnt_q   <= '0;
            scol_q  <= '0;
            spal_q  <= '0;
            sprio_q <= '0;
            disc_q  <= '0;
            vld_q   <= 1'b0;
            pix_q   <= 2'b00;
        end else begin
            bg_q    <= bg_d;
            cnt_q   <= cnt_d;
            scol_q  <= scol_d;
            spal_q  <= spal_d;
            sprio_q <= sprio_d;
            disc_q  <= disc_d;
            vld_q   <= vld_d;
            pix_q   <= pix_d;
        end
    end

endmodule

// File: tb/tb_ppu_pixel_fifo.sv
// Bench for ppu_pixel_fifo: directed scenarios plus random traffic,
// compared against a queue-based pixel pipeline model.
module tb_ppu_pixel_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       line_start;
    logic [2:0] discard;
    logic       bg_load;
    logic [7:0] bg_lo;
    logic [7:0] bg_hi;
    logic       bg_ready;
    logic       obj_load;
    logic [7:0] obj_lo;
    logic [7:0] obj_hi;
    logic       obj_pal;
    logic       obj_prio;
    logic       obj_ready;
    logic       bg_en;
    logic [7:0] bgp;
    logic [7:0] obp0;
    logic [7:0] obp1;
    logic [1:0] px_out;
    logic       px_valid;
    logic       px_ready;
    logic [4:0] bg_count;

    ppu_pixel_fifo #(.DEPTH(DEPTH), .OBJ_EN(1), .PAL_EN(1)) dut (
        .clk(clk), .rst(rst), .line_start(line_start), .discard(discard),
        .bg_load(bg_load), .bg_lo(bg_lo), .bg_hi(bg_hi),
        .bg_ready(bg_ready), .obj_load(obj_load), .obj_lo(obj_lo),
        .obj_hi(obj_hi), .obj_pal(obj_pal), .obj_prio(obj_prio),
        .obj_ready(obj_ready), .bg_en(bg_en), .bgp(bgp), .obp0(obp0),
        .obp1(obp1), .px_out(px_out), .px_valid(px_valid),
        .px_ready(px_ready), .bg_count(bg_count)
    );

    always #5 clk = ~clk;

    int q[$];
    int sc[8];
    int sp[8];
    int sr[8];
    int mdisc;
    int mvalid;
    int mout;
    int got[$];
    int vectors = 0;
    int errs = 0;
    int exp1[8] = '{3, 3, 1, 1, 2, 2, 0, 0};
    int exp2[3] = '{2, 0, 0};

    function automatic int bitof(input logic [7:0] v, input int i);
        return (int'(v) >> i) & 1;
    endfunction

    function automatic void clear_spr();
        for (int i = 0; i < 8; i++) begin
            sc[i] = 0;
            sp[i] = 0;
            sr[i] = 0;
        end
    endfunction

    // Next-state of the pixel pipeline from the current inputs
    function automatic void model();
        int cnt, bgc, idx, pal, use_o;
        bit pop, rb, ro;
        if (rst) begin
            q.delete();
            clear_spr();
            mdisc = 0;
            mvalid = 0;
            mout = 0;
            return;
        end
        if (line_start) begin
            q.delete();
            clear_spr();
            mvalid = 0;
            mdisc = int'(discard);
            return;
        end
        cnt = q.size();
        rb = (cnt <= DEPTH - 8);
        ro = (cnt >= 8);
        pop = (cnt > 0) && (mdisc > 0 || mvalid == 0 || px_ready);
        if (pop) begin
            bgc = bg_en ? q.pop_front() : 0;
            if (!bg_en) void'(q.pop_front());
            use_o = (sc[0] != 0) && (sr[0] == 0 || bgc == 0);
            idx = use_o ? sc[0] : bgc;
            pal = use_o ? (sp[0] != 0 ? int'(obp1) : int'(obp0)) : int'(bgp);
            for (int i = 0; i < 7; i++) begin
                sc[i] = sc[i+1];
                sp[i] = sp[i+1];
                sr[i] = sr[i+1];
            end
            sc[7] = 0;
            sp[7] = 0;
            sr[7] = 0;
            if (mdisc > 0) begin
                mdisc--;
                if (mvalid != 0 && px_ready) mvalid = 0;
            end else begin
                mvalid = 1;
                mout = (pal >> (2 * idx)) & 3;
            end
        end else if (mvalid != 0 && px_ready) begin
            mvalid = 0;
        end
        if (bg_load && rb) begin
            for (int i = 7; i >= 0; i--)
                q.push_back(2 * bitof(bg_hi, i) + bitof(bg_lo, i));
        end
        if (obj_load && ro) begin
            for (int i = 0; i < 8; i++) begin
                if (sc[i] == 0) begin
                    sc[i] = 2 * bitof(obj_hi, 7 - i) + bitof(obj_lo, 7 - i);
                    sp[i] = int'(obj_pal);
                    sr[i] = int'(obj_prio);
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check();
        chk("bg_count", 32'(bg_count), q.size());
        chk("px_valid", 32'(px_valid), mvalid);
        chk("bg_ready", 32'(bg_ready), 32'(q.size() <= DEPTH - 8));
        chk("obj_ready", 32'(obj_ready), 32'(q.size() >= 8));
        if (mvalid != 0) chk("px_out", 32'(px_out), mout);
    endtask

    task automatic step();
        model();
        if (px_valid && px_ready) got.push_back(int'(px_out));
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic run_sprite(input logic prio, input int shade);
        line_start = 1'b1;
        discard = 3'd0;
        step();
        line_start = 1'b0;
        px_ready = 1'b0;
        bg_lo = 8'hFF;
        bg_hi = 8'hFF;
        bg_load = 1'b1;
        step();
        bg_load = 1'b0;
        step();
        bg_load = 1'b1;
        step();
        bg_load = 1'b0;
        obj_load = 1'b1;
        obj_lo = 8'h80;
        obj_hi = 8'h00;
        obj_pal = 1'b0;
        obj_prio = prio;
        obp0 = 8'hD0;
        step();
        obj_load = 1'b0;
        px_ready = 1'b1;
        step();
        chk(prio ? "obj_prio1_px" : "obj_prio0_px", 32'(px_out), shade);
    endtask

    initial begin
        rst = 1'b1;
        line_start = 1'b0;
        discard = 3'd0;
        bg_load = 1'b0;
        bg_lo = 8'h00;
        bg_hi = 8'h00;
        obj_load = 1'b0;
        obj_lo = 8'h00;
        obj_hi = 8'h00;
        obj_pal = 1'b0;
        obj_prio = 1'b0;
        bg_en = 1'b1;
        bgp = 8'hE4;
        obp0 = 8'h00;
        obp1 = 8'h00;
        px_ready = 1'b1;
        step();
        step();
        chk("rst_px_out", 32'(px_out), 0);
        rst = 1'b0;

        line_start = 1'b1;
        step();
        line_start = 1'b0;
        bg_lo = 8'hF0;
        bg_hi = 8'hCC;
        bg_load = 1'b1;
        step();
        bg_load = 1'b0;
        chk("lat_cycle1", 32'(px_valid), 0);
        got.delete();
        step();
        chk("lat_cycle2", 32'(px_valid), 1);
        repeat (8) step();
        chk("row_len", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk("row_px", got[i], exp1[i]);

        line_start = 1'b1;
        discard = 3'd5;
        step();
        line_start = 1'b0;
        got.delete();
        bg_load = 1'b1;
        step();
        bg_load = 1'b0;
        repeat (12) step();
        chk("disc_len", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            chk("disc_px", got[i], exp2[i]);
        chk("disc_cnt", 32'(bg_count), 0);

        run_sprite(1'b0, 0);
        run_sprite(1'b1, 3);

        line_start = 1'b1;
        discard = 3'd0;
        step();
        line_start = 1'b0;
        bg_lo = 8'h0F;
        bg_hi = 8'h00;
        bg_load = 1'b1;
        step();
        bg_load = 1'b0;
        for (int i = 0; i < 40 && bg_count != 5'd0; i++) step();
        chk("drain", 32'(bg_count), 0);
        px_ready = 1'b0;
        bg_lo = 8'hFF;
        bg_hi = 8'hFF;
        bg_load = 1'b1;
        step();
        step();
        chk("full_cnt", 32'(bg_count), 16);
        chk("full_rdy", 32'(bg_ready), 0);
        step();
        chk("full_drop", 32'(bg_count), 16);
        bg_load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_px", 32'(px_out), 1);
        end

        obp0 = 8'h40;
        obp1 = 8'hFC;
        obj_load = 1'b1;
        obj_lo = 8'h80;
        obj_hi = 8'h80;
        obj_pal = 1'b0;
        obj_prio = 1'b0;
        step();
        obj_hi = 8'h00;
        obj_pal = 1'b1;
        step();
        obj_load = 1'b0;
        px_ready = 1'b1;
        step();
        chk("overlap_px", 32'(px_out), 1);

        for (int i = 0; i < 20 && bg_count != 5'd9; i++) step();
        chk("reach9", 32'(bg_count), 9);
        line_start = 1'b1;
        bg_load = 1'b1;
        step();
        line_start = 1'b0;
        bg_load = 1'b0;
        chk("ls_cnt", 32'(bg_count), 0);
        chk("ls_valid", 32'(px_valid), 0);

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom % 500) == 0;
            line_start = ($urandom % 80) == 0;
            discard = 3'($urandom);
            bg_load = ($urandom % 3) == 0;
            bg_lo = 8'($urandom);
            bg_hi = 8'($urandom);
            obj_load = ($urandom % 4) == 0;
            obj_lo = 8'($urandom);
            obj_hi = 8'($urandom);
            obj_pal = 1'($urandom);
            obj_prio = 1'($urandom);
            bg_en = ($urandom % 10) != 0;
            px_ready = ($urandom % 4) != 0;
            if (($urandom % 50) == 0) begin
                bgp = 8'($urandom);
                obp0 = 8'($urandom);
                obp1 = 8'($urandom);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
